// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-front-end program counter.
// Holds the control-state encoding and the two instruction-size increments.
package pc_gen_pkg;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'b00,
      ST_RUN    = 2'b01,
      ST_HALTED = 2'b10
   } pc_state_e;

   localparam logic [2:0] INC_16 = 3'd2;
   localparam logic [2:0] INC_32 = 3'd4;

   // Byte step for the instruction currently at the PC.
   function automatic logic [2:0] inc_size(input logic support_c, input logic compressed);
      logic [2:0] step;
      if (support_c && compressed) begin
         step = INC_16;
      end else begin
         step = INC_32;
      end
      return step;
   endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Redirect, halt and fetch-handshake bundle between execute/trap logic, pc_gen and fetch.
// The master modport is the PC generator; the slave modport is its environment.
interface pc_gen_if #(
   parameter int XLEN = 64
);
   logic            trap_valid;
   logic [XLEN-1:0] trap_target;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_target;
   logic            halt_req;
   logic            resume_req;
   logic            fetch_ready;
   logic            instr_compressed;
   logic [XLEN-1:0] pc_out;
   logic            pc_valid;
   logic            pc_misaligned;
   logic [1:0]      state_out;
   logic [XLEN-1:0] fetch_count;

   modport master (
      input  trap_valid, trap_target, redirect_valid, redirect_target,
      input  halt_req, resume_req, fetch_ready, instr_compressed,
      output pc_out, pc_valid, pc_misaligned, state_out, fetch_count
   );

   modport slave (
      output trap_valid, trap_target, redirect_valid, redirect_target,
      output halt_req, resume_req, fetch_ready, instr_compressed,
      input  pc_out, pc_valid, pc_misaligned, state_out, fetch_count
   );
endinterface

// File: rtl/pc_gen_next_sel.sv
// Combinational next-PC selection: trap over redirect over sequential increment,
// with target alignment masking and misalignment detection.
module pc_next_sel
   import pc_gen_pkg::*;
#(
   parameter int XLEN      = 64,
   parameter bit SUPPORT_C = 1'b1
) (
   input  logic [XLEN-1:0] pc,
   input  logic            trap_en,
   input  logic [XLEN-1:0] trap_target,
   input  logic            redirect_en,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            inc_en,
   input  logic            compressed,
   output logic [XLEN-1:0] next_pc,
   output logic            load,
   output logic            misaligned
);

   logic [XLEN-1:0] sel_target_s;
   logic [XLEN-1:0] inc_s;

   // Without compressed support targets are forced onto 4-byte boundaries.
   function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] t);
      logic [XLEN-1:0] a;
      a = t;
      a[0] = 1'b0;
      if (!SUPPORT_C) begin
         a[1] = 1'b0;
      end else begin
         a[1] = t[1];
      end
      return a;
   endfunction

   function automatic logic target_misaligned(input logic [XLEN-1:0] t);
      logic m;
      if (!SUPPORT_C) begin
         m = t[1];
      end else begin
         m = 1'b0;
      end
      return m;
   endfunction

   assign inc_s = {{(XLEN-3){1'b0}}, inc_size(SUPPORT_C, compressed)};

   // Priority mux for the PC that will be registered on the next edge.
   always_comb begin
      sel_target_s = redirect_target;
      next_pc      = pc;
      misaligned   = 1'b0;
      load         = trap_en | redirect_en;
      if (trap_en) begin
         sel_target_s = trap_target;
      end else begin
         sel_target_s = redirect_target;
      end
      if (load) begin
         next_pc    = align_target(sel_target_s);
         misaligned = target_misaligned(sel_target_s);
      end else if (inc_en) begin
         next_pc    = pc + inc_s;
         misaligned = 1'b0;
      end else begin
         next_pc    = pc;
         misaligned = 1'b0;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// RISC-V fetch program counter: BOOT/RUN/HALTED control, redirects, valid/ready
// handshake to fetch, sticky misalignment flag and accepted-fetch counter.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int          XLEN         = 64,
   parameter logic [63:0] RESET_VECTOR = 64'h0,
   parameter bit          SUPPORT_C    = 1'b1
) (
   input logic     clk,
   input logic     reset_n,
   pc_gen_if.master bus
);

   localparam logic [XLEN-1:0] RST_PC  = RESET_VECTOR[XLEN-1:0];
   localparam logic [XLEN-1:0] CNT_ONE = {{(XLEN-1){1'b0}}, 1'b1};

   pc_state_e       state_r;
   pc_state_e       state_nxt_s;
   logic [XLEN-1:0] pc_r;
   logic [XLEN-1:0] cnt_r;
   logic            valid_r;
   logic            mis_r;
   logic [XLEN-1:0] next_pc_s;
   logic            handshake_s;
   logic            trap_en_s;
   logic            redirect_en_s;
   logic            load_s;
   logic            mis_s;

   // valid_r is high exactly in RUN, so it doubles as the handshake qualifier.
   assign handshake_s = valid_r & bus.fetch_ready;

   // Next-state decode and gating of redirect sources by control state.
   always_comb begin
      state_nxt_s   = state_r;
      trap_en_s     = 1'b0;
      redirect_en_s = 1'b0;
      case (state_r)
         ST_BOOT: begin
            state_nxt_s = ST_RUN;
         end
         ST_RUN: begin
            trap_en_s     = bus.trap_valid;
            redirect_en_s = bus.redirect_valid;
            if (bus.halt_req) begin
               state_nxt_s = ST_HALTED;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_HALTED: begin
            trap_en_s     = bus.trap_valid;
            redirect_en_s = bus.redirect_valid;
            if (bus.trap_valid) begin
               state_nxt_s = ST_RUN;
            end else if (bus.resume_req && !bus.halt_req) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_HALTED;
            end
         end
         default: begin
            state_nxt_s = ST_BOOT;
         end
      endcase
   end

   pc_next_sel #(
      .XLEN      (XLEN),
      .SUPPORT_C (SUPPORT_C)
   ) u_next_sel (
      .pc              (pc_r),
      .trap_en         (trap_en_s),
      .trap_target     (bus.trap_target),
      .redirect_en     (redirect_en_s),
      .redirect_target (bus.redirect_target),
      .inc_en          (handshake_s),
      .compressed      (bus.instr_compressed),
      .next_pc         (next_pc_s),
      .load            (load_s),
      .misaligned      (mis_s)
   );

   // State, PC, valid, sticky misalignment flag and fetch counter registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r <= ST_BOOT;
         pc_r    <= RST_PC;
         valid_r <= 1'b0;
         mis_r   <= 1'b0;
         cnt_r   <= {XLEN{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         pc_r    <= next_pc_s;
         valid_r <= (state_nxt_s == ST_RUN);
         if (load_s) begin
            mis_r <= mis_s;
         end
         if (handshake_s) begin
            cnt_r <= cnt_r + CNT_ONE;
         end
      end
   end

   assign bus.pc_out        = pc_r;
   assign bus.pc_valid      = valid_r;
   assign bus.pc_misaligned = mis_r;
   assign bus.state_out     = state_r;
   assign bus.fetch_count   = cnt_r;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: two instances (64-bit with compressed support, 32-bit without)
// driven identically and checked every cycle against a behavioural model.
module tb_pc_gen;
   import pc_gen_pkg::*;

   localparam logic [63:0] RV = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        trap_valid, redirect_valid, halt_req, resume_req, fetch_ready, instr_compressed;
   logic [63:0] trap_target, redirect_target;

   always #5 clk = ~clk;

   pc_gen_if #(.XLEN(64)) if_c ();
   pc_gen_if #(.XLEN(32)) if_n ();

   assign if_c.trap_valid       = trap_valid;
   assign if_c.trap_target      = trap_target;
   assign if_c.redirect_valid   = redirect_valid;
   assign if_c.redirect_target  = redirect_target;
   assign if_c.halt_req         = halt_req;
   assign if_c.resume_req       = resume_req;
   assign if_c.fetch_ready      = fetch_ready;
   assign if_c.instr_compressed = instr_compressed;
   assign if_n.trap_valid       = trap_valid;
   assign if_n.trap_target      = trap_target[31:0];
   assign if_n.redirect_valid   = redirect_valid;
   assign if_n.redirect_target  = redirect_target[31:0];
   assign if_n.halt_req         = halt_req;
   assign if_n.resume_req       = resume_req;
   assign if_n.fetch_ready      = fetch_ready;
   assign if_n.instr_compressed = instr_compressed;

   pc_gen #(.XLEN(64), .RESET_VECTOR(RV), .SUPPORT_C(1'b1)) dut_c (
      .clk(clk), .reset_n(reset_n), .bus(if_c.master));
   pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .SUPPORT_C(1'b0)) dut_n (
      .clk(clk), .reset_n(reset_n), .bus(if_n.master));

   // Behavioural model: index 0 = 64-bit with C, index 1 = 32-bit without C.
   logic [63:0] m_pc [2];
   logic [63:0] m_cnt[2];
   logic        m_valid[2];
   logic        m_mis[2];
   int          m_st[2];   // 0 boot, 1 run, 2 halted

   int n_cmp = 0;
   int n_bad = 0;
   logic chk_en = 1'b0;

   logic        lit_on = 1'b0;
   int          lit_i;
   logic [63:0] lit_pc, lit_cnt;
   logic [1:0]  lit_st;
   logic        lit_valid, lit_mis;

   function automatic logic [63:0] msk(input int i);
      return (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
   endfunction

   task automatic model_load(input int i, input logic [63:0] t);
      if (i == 0) begin
         m_pc[i]  = t & msk(i) & ~64'd1;
         m_mis[i] = 1'b0;
      end else begin
         m_pc[i]  = t & msk(i) & ~64'd3;
         m_mis[i] = t[1];
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         if (!reset_n) begin
            m_pc[i] = RV & msk(i); m_cnt[i] = 64'd0; m_mis[i] = 1'b0; m_st[i] = 0;
         end else if (m_st[i] == 0) begin
            m_st[i] = 1;
         end else if (m_st[i] == 1) begin
            if (fetch_ready) m_cnt[i] = (m_cnt[i] + 64'd1) & msk(i);
            if (trap_valid) model_load(i, trap_target);
            else if (redirect_valid) model_load(i, redirect_target);
            else if (fetch_ready)
               m_pc[i] = (m_pc[i] + ((i == 0 && instr_compressed) ? 64'd2 : 64'd4)) & msk(i);
            if (halt_req) m_st[i] = 2;
         end else begin
            if (trap_valid) begin
               model_load(i, trap_target);
               m_st[i] = 1;
            end else begin
               if (redirect_valid) model_load(i, redirect_target);
               if (resume_req && !halt_req) m_st[i] = 1;
            end
         end
         m_valid[i] = (m_st[i] == 1);
      end
   endtask

   task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d] t=%0t: got %h, want %h", nm, i, $time, act, exp);
      end
   endtask

   // Single compare process: DUT against model every cycle, literals against both.
   always @(negedge clk) begin : cmp
      logic [63:0] a_pc, a_cnt;
      logic [1:0]  a_st;
      logic        a_v, a_m;
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
               a_pc = if_c.pc_out; a_cnt = if_c.fetch_count; a_st = if_c.state_out;
               a_v = if_c.pc_valid; a_m = if_c.pc_misaligned;
            end else begin
               a_pc = {32'h0, if_n.pc_out}; a_cnt = {32'h0, if_n.fetch_count};
               a_st = if_n.state_out; a_v = if_n.pc_valid; a_m = if_n.pc_misaligned;
            end
            chk("pc_out", i, a_pc, m_pc[i]);
            chk("fetch_count", i, a_cnt, m_cnt[i]);
            chk("state_out", i, {62'd0, a_st}, 64'(m_st[i]));
            chk("pc_valid", i, {63'd0, a_v}, {63'd0, m_valid[i]});
            chk("pc_misaligned", i, {63'd0, a_m}, {63'd0, m_mis[i]});
            if (lit_on && lit_i == i) begin
               chk("lit_model_pc", i, m_pc[i], lit_pc);
               chk("lit_model_cnt", i, m_cnt[i], lit_cnt);
               chk("lit_dut_pc", i, a_pc, lit_pc);
               chk("lit_dut_cnt", i, a_cnt, lit_cnt);
               chk("lit_dut_state", i, {62'd0, a_st}, {62'd0, lit_st});
               chk("lit_dut_valid", i, {63'd0, a_v}, {63'd0, lit_valid});
               chk("lit_dut_mis", i, {63'd0, a_m}, {63'd0, lit_mis});
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      lit_on = 1'b0;
   endtask

   task automatic idle();
      trap_valid = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0; resume_req = 1'b0;
   endtask

   task automatic expect_lit(input int i, input logic [63:0] pc, input logic [63:0] cnt,
                             input logic [1:0] st, input logic v, input logic m);
      lit_i = i; lit_pc = pc; lit_cnt = cnt; lit_st = st; lit_valid = v; lit_mis = m;
      lit_on = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0; idle(); fetch_ready = 1'b1; instr_compressed = 1'b0;
      trap_target = 64'd0; redirect_target = 64'd0;
      step(); chk_en = 1'b1;
      step(); expect_lit(0, RV, 64'd0, 2'b00, 1'b0, 1'b0);
      // Boot then sequential fetch
      reset_n = 1'b1;
      step(); expect_lit(0, RV, 64'd0, 2'b01, 1'b1, 1'b0);
      step(); expect_lit(0, RV + 64'd4, 64'd1, 2'b01, 1'b1, 1'b0);
      step(); expect_lit(1, RV + 64'd8, 64'd2, 2'b01, 1'b1, 1'b0);
      // Compressed increments from 0x100
      fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 64'h100;
      step(); expect_lit(0, 64'h100, 64'd2, 2'b01, 1'b1, 1'b0);
      idle(); fetch_ready = 1'b1; instr_compressed = 1'b1;
      step(); expect_lit(0, 64'h102, 64'd3, 2'b01, 1'b1, 1'b0);
      instr_compressed = 1'b0;
      step(); expect_lit(0, 64'h106, 64'd4, 2'b01, 1'b1, 1'b0);
      instr_compressed = 1'b1;
      step(); expect_lit(1, 64'h10C, 64'd5, 2'b01, 1'b1, 1'b0);
      // Trap beats redirect beats handshake
      instr_compressed = 1'b0; fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 64'h40;
      step(); expect_lit(0, 64'h40, 64'd5, 2'b01, 1'b1, 1'b0);
      trap_valid = 1'b1; trap_target = 64'h200; redirect_target = 64'h300; fetch_ready = 1'b1;
      step(); expect_lit(0, 64'h200, 64'd6, 2'b01, 1'b1, 1'b0);
      // Misalignment without compressed support
      idle(); fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 64'h1006;
      step(); expect_lit(1, 64'h1004, 64'd6, 2'b01, 1'b1, 1'b1);
      redirect_target = 64'h2000;
      step(); expect_lit(1, 64'h2000, 64'd6, 2'b01, 1'b1, 1'b0);
      // Halt, redirect while halted, resume
      redirect_target = 64'h10;
      step(); expect_lit(0, 64'h10, 64'd6, 2'b01, 1'b1, 1'b0);
      idle(); halt_req = 1'b1;
      step(); expect_lit(0, 64'h10, 64'd6, 2'b10, 1'b0, 1'b0);
      halt_req = 1'b0; redirect_valid = 1'b1; redirect_target = 64'h50;
      step(); expect_lit(0, 64'h50, 64'd6, 2'b10, 1'b0, 1'b0);
      idle(); fetch_ready = 1'b1;
      step(); expect_lit(0, 64'h50, 64'd6, 2'b10, 1'b0, 1'b0);
      resume_req = 1'b1;
      step(); expect_lit(0, 64'h50, 64'd6, 2'b01, 1'b1, 1'b0);
      resume_req = 1'b0;
      step(); expect_lit(0, 64'h54, 64'd7, 2'b01, 1'b1, 1'b0);
      // Wrap at the top of the address space, then reset while halted
      fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
      step(); expect_lit(1, 64'hFFFF_FFFC, 64'd7, 2'b01, 1'b1, 1'b0);
      idle(); fetch_ready = 1'b1;
      step(); expect_lit(0, 64'd0, 64'd8, 2'b01, 1'b1, 1'b0);
      fetch_ready = 1'b0;
      step(); expect_lit(1, 64'd0, 64'd8, 2'b01, 1'b1, 1'b0);
      halt_req = 1'b1;
      step(); expect_lit(0, 64'd0, 64'd8, 2'b10, 1'b0, 1'b0);
      halt_req = 1'b0; reset_n = 1'b0;
      step(); expect_lit(1, RV, 64'd0, 2'b00, 1'b0, 1'b0);
      reset_n = 1'b1;
      // Randomised traffic
      for (int k = 0; k < 3000; k++) begin
         reset_n          = ($urandom_range(0, 199) != 0);
         trap_valid       = ($urandom_range(0, 15) == 0);
         redirect_valid   = ($urandom_range(0, 7) == 0);
         halt_req         = ($urandom_range(0, 19) == 0);
         resume_req       = ($urandom_range(0, 3) == 0);
         fetch_ready      = ($urandom_range(0, 3) != 0);
         instr_compressed = 1'($urandom_range(0, 1));
         trap_target      = {$urandom, $urandom};
         redirect_target  = {$urandom, $urandom};
         if ($urandom_range(0, 9) == 0) redirect_target = 64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) trap_target = 64'($urandom_range(0, 4095));
         step();
      end
      idle();
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
